// File: rtl/alu_pkg.sv
// Shared mode encodings and FSM state type for the serial negator.
package alu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/negate_slice.sv
// CHUNK-wide conditional-invert ripple incrementer built from full_adder cells.
module negate_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             invert,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  logic [CHUNK:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (chunk[i] ^ invert),
      .b    (1'b0),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign carry_out = carry[CHUNK];

endmodule

// File: rtl/serial_negator.sv
// Chunk-serial pass/ones-complement/negate/abs unit with valid/ready handshakes.
// Optional overflow flag output is enabled by defining NEG_OVF_FLAG_EN.
module serial_negator
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef NEG_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_negator: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             invert_q, invert_d;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             negate;

  negate_slice #(.CHUNK(CHUNK)) u_slice (
    .chunk     (data_q[CHUNK-1:0]),
    .invert    (invert_q),
    .carry_in  (carry_q),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  assign negate = (in_mode == MODE_NEG) || ((in_mode == MODE_ABS) && in_data[WIDTH-1]);

  // data_q is a shift register: operand chunks leave at the bottom while
  // result chunks enter at the top, so it holds the full result in DONE.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    invert_d = invert_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          cnt_d    = '0;
          carry_d  = negate;
          invert_d = negate || (in_mode == MODE_ONES);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        data_d  = (data_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      invert_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      invert_q <= invert_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? data_q : '0;

`ifdef NEG_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      ovf_d = ((in_mode == MODE_NEG) || (in_mode == MODE_ABS)) && (in_data == MIN_NEG);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = (state_q == DONE) ? ovf_q : 1'b0;
`else
  // Without the flag build the most-negative constant has no consumer.
  logic unused_min_neg;
  assign unused_min_neg = ^MIN_NEG;
`endif

endmodule
